uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the v65C02 UART, the receive-side counterpart of `UART_TX`. It takes the asynchronous RX line and recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) using the shared 16x baud-rate strobe. Each received byte is presented on a parallel holding register with ready, framing-error and overrun flags, for the UART register interface to read.

## Interface
Parameters:
- none (frame format fixed at 8N1, oversampling fixed at 16x)

Ports:
- `clk_i` in 1: system clock; all logic on rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `brg_stb_i` in 1: one-`clk_i` pulse at 16x baud, shared with `UART_TX`.
- `rxd_i` in 1: asynchronous serial input, idle high.
- `rd_i` in 1: one-cycle read acknowledge from the host side.
- `dout_o` out 8: last received byte.
- `rdy_o` out 1: `dout_o` holds an unread byte.
- `ferr_o` out 1: stop bit of the byte in `dout_o` was sampled low.
- `oerr_o` out 1: a byte completed while `rdy_o` was still set (sticky).
- `busy_o` out 1: a frame is in progress (state other than IDLE).

## Operation
- Input sync: 2-flop synchronizer on `rxd_i`; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- Counters:
  - 4-bit tick counter `tick`, advanced only on `brg_stb_i`; wraps 15→0.
  - 3-bit bit index `bitn`.
- States:
  - IDLE: on `brg_stb_i` with `rx_s`=0 → START, `tick`=0.
  - START: on the strobe where `tick`=7 (mid start bit), check `rx_s`.
    - `rx_s`=0: → DATA, `tick`=0, `bitn`=0.
    - `rx_s`=1: false start (glitch) → IDLE. No flags change.
  - DATA: on the strobe where `tick`=15, shift `rx_s` into shift register bit 7 (shift right, LSB first) and restart `tick`.
    - `bitn`=7 → STOP; otherwise `bitn`+1.
  - STOP: on the strobe where `tick`=15 (mid stop bit), capture the byte and the stop sample (see below).
    - Stop sample 1 → IDLE.
    - Stop sample 0 → BRK.
  - BRK: wait for `rx_s`=1 on a `brg_stb_i`, then → IDLE. Prevents a break or stuck-low line from retriggering.
- Capture at STOP:
  - `dout_o` ← shift register.
  - `ferr_o` ← ~stop sample.
  - `rdy_o` ← 1.
  - If `rdy_o` was already 1 and `rd_i` is not asserted in the same cycle: `oerr_o` ← 1. The new byte overwrites `dout_o`.
- Read (`rd_i`=1 in a cycle without capture):
  - `rdy_o`, `ferr_o` and `oerr_o` ← 0.
  - `dout_o` is unchanged.
  - `rd_i` while `rdy_o`=0 has no effect.
- Simultaneous capture and `rd_i`: the capture wins.
  - `rdy_o`=1, `dout_o` holds the new byte, `ferr_o` reflects the new byte.
  - `oerr_o` is cleared, not set.
- `busy_o` = (state ≠ IDLE).

## Timing
- Reset values: `dout_o`=0x00, `rdy_o`=0, `ferr_o`=0, `oerr_o`=0, `busy_o`=0; state IDLE, `tick`=0, `bitn`=0, synchronizer=1.
- Reset mid-frame drops the partial byte, flags and state within one `clk_i` edge. After reset release, reception resumes only from the next falling edge.
- Synchronizer latency: 2 `clk_i`.
- Sample points: mid start bit is 8 strobes after the start edge is detected. Each subsequent bit is sampled 16 strobes after the previous sample.
- `rdy_o`, `ferr_o`, `oerr_o` and `dout_o` update on the `clk_i` edge that registers the stop-bit sample strobe, i.e. about 9.5 bit times after the start edge.
- Throughput: back-to-back frames with no idle gap are received. IDLE is re-entered half a bit time before the next start bit.
- Clock tolerance: about ±3% total baud mismatch.
- `rd_i` is not qualified by `brg_stb_i`; it acts in any cycle.

## Test plan
All scenarios use a 10 ns clock and `brg_stb_i` every 4 clocks, so one bit = 64 clocks.
- Single byte: drive frame 0x75 → exactly one `rdy_o` rise, `dout_o`=0x75, `ferr_o`=0, `oerr_o`=0, `busy_o` low after the stop sample. Pulse `rd_i` → `rdy_o`=0.
- Back-to-back with read between: frames 0x75 then 0x53 with no gap, `rd_i` after the first → `dout_o`=0x75 then 0x53, `oerr_o` stays 0.
- Overrun: frames 0xA5 then 0x3C with no `rd_i` → `dout_o`=0x3C, `rdy_o`=1, `oerr_o`=1. One `rd_i` → all three flags cleared.
- Framing error / break: frame 0x81 with stop bit low, then line held low for 20 bit times → `dout_o`=0x81, `ferr_o`=1, no further `rdy_o` events. After the line returns high, frame 0x42 → received normally with `ferr_o`=0.
- Glitch: 3-strobe low pulse on an idle line → no `rdy_o`, `busy_o` returns to 0 within 8 strobes. A following 0x55 frame → received correctly.
- Reset mid-frame: assert `rst_i` for 1 clock during data bit 3 of 0xF0 → all outputs at reset values, no `rdy_o` for that frame. The next frame 0x0F → `dout_o`=0x0F. Also cover `rd_i` coinciding with the capture cycle → `rdy_o`=1, `oerr_o`=0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver driven by the shared 16x baud strobe.
// Recovers one byte per frame into a holding register with ready,
// framing-error and sticky overrun flags for the host register interface.
`timescale 1ns/1ps

module uart_rx (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       brg_stb_i,
  input  logic       rxd_i,
  input  logic       rd_i,
  output logic [7:0] dout_o,
  output logic       rdy_o,
  output logic       ferr_o,
  output logic       oerr_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t     state_reg;
  logic       rx_meta_reg;
  logic       rx_s_reg;
  logic [3:0] tick_reg;
  logic [2:0] bitn_reg;
  logic [7:0] shift_reg;
  logic [7:0] dout_reg;
  logic       rdy_reg;
  logic       ferr_reg;
  logic       oerr_reg;
  logic       capture;

  // The stop bit is sampled on this strobe; the byte is handed over here.
  assign capture = (state_reg == STOP) && brg_stb_i && (tick_reg == 4'd15);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rxd_i;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // Frame FSM: start validation, mid-bit sampling, stop check, break hold-off.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      tick_reg  <= 4'd0;
      bitn_reg  <= 3'd0;
      shift_reg <= 8'h00;
    end else if (brg_stb_i) begin
      case (state_reg)
        IDLE: begin
          tick_reg <= 4'd0;
          if (!rx_s_reg) begin
            state_reg <= START;
          end
        end
        START: begin
          if (tick_reg == 4'd7) begin
            tick_reg <= 4'd0;
            if (!rx_s_reg) begin
              // Start bit still low at its centre: a real frame.
              state_reg <= DATA;
              bitn_reg  <= 3'd0;
            end else begin
              // Line went back high: treat as a glitch.
              state_reg <= IDLE;
            end
          end else begin
            tick_reg <= tick_reg + 4'd1;
          end
        end
        DATA: begin
          // Wraps 15 -> 0 so each sample is exactly 16 strobes apart.
          tick_reg <= tick_reg + 4'd1;
          if (tick_reg == 4'd15) begin
            shift_reg <= {rx_s_reg, shift_reg[7:1]};
            if (bitn_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              bitn_reg <= bitn_reg + 3'd1;
            end
          end
        end
        STOP: begin
          tick_reg <= tick_reg + 4'd1;
          if (tick_reg == 4'd15) begin
            // A low stop bit means break or framing error: wait for idle.
            state_reg <= rx_s_reg ? IDLE : BRK;
          end
        end
        BRK: begin
          tick_reg <= 4'd0;
          if (rx_s_reg) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          tick_reg  <= 4'd0;
        end
      endcase
    end
  end

  // Holding register and flags; a capture takes priority over a read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_reg <= 8'h00;
      rdy_reg  <= 1'b0;
      ferr_reg <= 1'b0;
      oerr_reg <= 1'b0;
    end else if (capture) begin
      dout_reg <= shift_reg;
      ferr_reg <= ~rx_s_reg;
      rdy_reg  <= 1'b1;
      if (rd_i) begin
        oerr_reg <= 1'b0;
      end else if (rdy_reg) begin
        oerr_reg <= 1'b1;
      end
    end else if (rd_i && rdy_reg) begin
      rdy_reg  <= 1'b0;
      ferr_reg <= 1'b0;
      oerr_reg <= 1'b0;
    end
  end

  assign dout_o = dout_reg;
  assign rdy_o  = rdy_reg;
  assign ferr_o = ferr_reg;
  assign oerr_o = oerr_reg;
  assign busy_o = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Frames are built bit by bit,
// a frame-level model predicts each delivered byte and its flags, and a
// monitor compares every capture it observes against the queue.
`timescale 1ns/1ps

module tb_uart_rx;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       brg_stb_i;
  logic       rxd_i;
  logic       rd_i;
  logic [7:0] dout_o;
  logic       rdy_o;
  logic       ferr_o;
  logic       oerr_o;
  logic       busy_o;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       o;
  } exp_t;

  exp_t exp_q[$];

  // Host-visible model state: an unread byte is pending / overrun latched.
  bit m_rdy  = 1'b0;
  bit m_oerr = 1'b0;

  int stb_cnt = 0;

  uart_rx dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .brg_stb_i (brg_stb_i),
    .rxd_i     (rxd_i),
    .rd_i      (rd_i),
    .dout_o    (dout_o),
    .rdy_o     (rdy_o),
    .ferr_o    (ferr_o),
    .oerr_o    (oerr_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // 16x strobe every 4 clocks: one bit time = 64 clocks.
  always @(posedge clk_i) stb_cnt <= (stb_cnt == 3) ? 0 : stb_cnt + 1;
  assign brg_stb_i = (stb_cnt == 3);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait n rising edges, then step 1 ns past the edge.
  task automatic hold(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Land 1 ns after an edge that sampled the strobe high.
  task automatic align();
    do begin
      @(posedge clk_i);
      #1;
    end while (stb_cnt != 0);
  endtask

  task automatic do_read();
    rd_i = 1'b1;
    hold(1);
    rd_i = 1'b0;
    m_rdy  = 1'b0;
    m_oerr = 1'b0;
  endtask

  // rd_mode: 0 none, 1 read during the start bit, 2 read on the capture cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_mode);
    exp_t e;
    if (rd_mode == 1) begin
      m_rdy  = 1'b0;
      m_oerr = 1'b0;
    end
    e.d = d;
    e.f = ~stop;
    e.o = (rd_mode == 2) ? 1'b0 : (m_rdy | m_oerr);
    m_rdy  = 1'b1;
    m_oerr = e.o;
    exp_q.push_back(e);

    rxd_i = 1'b0;
    if (rd_mode == 1) begin
      rd_i = 1'b1;
      hold(1);
      rd_i = 1'b0;
      hold(63);
    end else begin
      hold(64);
    end
    for (int i = 0; i < 8; i++) begin
      rxd_i = d[i];
      hold(64);
    end
    rxd_i = stop;
    if (rd_mode == 2) begin
      // Stop sample lands 36 clocks into the stop bit.
      hold(35);
      rd_i = 1'b1;
      hold(1);
      rd_i = 1'b0;
      hold(28);
    end else begin
      hold(64);
    end
  endtask

  // Monitor: any capture shows up as rdy rising or new content while rdy is set.
  logic [7:0] p_dout = 8'h00;
  logic       p_rdy  = 1'b0;
  logic       p_ferr = 1'b0;
  logic       p_oerr = 1'b0;

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && rdy_o === 1'b1 &&
        (!p_rdy || dout_o !== p_dout || ferr_o !== p_ferr || (oerr_o && !p_oerr))) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_capture: got dout=%02h ferr=%0b oerr=%0b expected none at %0t",
                 dout_o, ferr_o, oerr_o, $time);
      end else begin
        e = exp_q.pop_front();
        if (dout_o !== e.d || ferr_o !== e.f || oerr_o !== e.o) begin
          miscompares++;
          $display("FAIL capture: got dout=%02h ferr=%0b oerr=%0b expected dout=%02h ferr=%0b oerr=%0b at %0t",
                   dout_o, ferr_o, oerr_o, e.d, e.f, e.o, $time);
        end else begin
          $display("rx byte %02h ferr=%0b oerr=%0b ok at %0t", dout_o, ferr_o, oerr_o, $time);
        end
      end
    end
    p_dout = dout_o;
    p_rdy  = rdy_o;
    p_ferr = ferr_o;
    p_oerr = oerr_o;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] last_d;
    logic       stop;
    int         mode;

    rst_i = 1'b1;
    rxd_i = 1'b1;
    rd_i  = 1'b0;
    hold(3);
    chk("reset_dout", dout_o, 8'h00);
    chk("reset_rdy", rdy_o, 0);
    chk("reset_ferr", ferr_o, 0);
    chk("reset_oerr", oerr_o, 0);
    chk("reset_busy", busy_o, 0);
    rst_i = 1'b0;
    hold(10);

    // Single byte, then read.
    align();
    send_frame(8'h75, 1'b1, 0);
    chk("single_busy", busy_o, 0);
    chk("single_rdy", rdy_o, 1);
    chk("single_dout", dout_o, 8'h75);
    chk("single_ferr", ferr_o, 0);
    chk("single_oerr", oerr_o, 0);
    do_read();
    chk("single_read_rdy", rdy_o, 0);

    // Back-to-back with a read between them.
    align();
    send_frame(8'h75, 1'b1, 0);
    send_frame(8'h53, 1'b1, 1);
    chk("b2b_dout", dout_o, 8'h53);
    chk("b2b_oerr", oerr_o, 0);

    // Overrun.
    send_frame(8'hA5, 1'b1, 1);
    send_frame(8'h3C, 1'b1, 0);
    chk("ovr_dout", dout_o, 8'h3C);
    chk("ovr_rdy", rdy_o, 1);
    chk("ovr_oerr", oerr_o, 1);
    do_read();
    chk("ovr_read_rdy", rdy_o, 0);
    chk("ovr_read_oerr", oerr_o, 0);
    chk("ovr_read_ferr", ferr_o, 0);
    chk("ovr_read_dout", dout_o, 8'h3C);

    // Framing error followed by a 20-bit break.
    align();
    send_frame(8'h81, 1'b0, 0);
    hold(20 * 64);
    chk("brk_dout", dout_o, 8'h81);
    chk("brk_ferr", ferr_o, 1);
    chk("brk_busy", busy_o, 1);
    rxd_i = 1'b1;
    hold(64);
    chk("brk_release_busy", busy_o, 0);
    align();
    send_frame(8'h42, 1'b1, 1);
    chk("after_brk_ferr", ferr_o, 0);
    chk("after_brk_dout", dout_o, 8'h42);

    // Glitch of 3 strobes on an idle line.
    hold(64);
    align();
    rxd_i = 1'b0;
    hold(12);
    rxd_i = 1'b1;
    chk("glitch_busy_high", busy_o, 1);
    hold(40);
    chk("glitch_busy_low", busy_o, 0);
    send_frame(8'h55, 1'b1, 1);
    chk("glitch_next_dout", dout_o, 8'h55);

    // Reset during data bit 3 of 0xF0; 0x55 is still unread.
    hold(64);
    align();
    rxd_i = 1'b0;
    hold(64);
    for (int i = 0; i < 3; i++) hold(64);
    hold(32);
    rst_i = 1'b1;
    hold(1);
    rst_i = 1'b0;
    rxd_i = 1'b1;
    m_rdy  = 1'b0;
    m_oerr = 1'b0;
    chk("midrst_dout", dout_o, 8'h00);
    chk("midrst_rdy", rdy_o, 0);
    chk("midrst_busy", busy_o, 0);
    hold(128);
    chk("midrst_idle_busy", busy_o, 0);
    align();
    send_frame(8'h0F, 1'b1, 0);
    chk("midrst_next_dout", dout_o, 8'h0F);

    // Read on the capture cycle: capture wins, no overrun.
    send_frame(8'h99, 1'b1, 2);
    chk("coinc_rdy", rdy_o, 1);
    chk("coinc_oerr", oerr_o, 0);
    chk("coinc_dout", dout_o, 8'h99);

    // Randomized frames, gaps, stop bits and read timing.
    last_d = 8'h99;
    for (int n = 0; n < 16; n++) begin
      do d = 8'($urandom_range(0, 255)); while (d == last_d);
      last_d = d;
      stop = ($urandom_range(0, 5) != 0);
      mode = $urandom_range(0, 2);
      send_frame(d, stop, mode);
      rxd_i = 1'b1;
      if (!stop) hold(64);
      hold($urandom_range(0, 20) * 4);
    end

    hold(200);
    chk("pending_expectations", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
